// File: rtl/uart_rx_fifo_if.sv
// Byte stream handshake between the UART receiver FIFO and its consumer.
// Ports: out_data (FIFO head byte), out_valid (FIFO not empty), out_ready (consumer accept).
// A byte moves on any clock edge where out_valid and out_ready are both high.
interface uart_rx_fifo_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  // Receiver side drives the byte and its valid flag.
  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  // Consumer side drives ready.
  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver (LSB first, idle-high line) feeding a small circular byte FIFO.
// Latency: 2-flop synchroniser plus mid-bit sampling; a byte appears 1 clk after its stop sample.
// Backpressure: out_ready holds bytes in the FIFO; a byte arriving while full with no pop is dropped (overrun).
//
// Ports:
//   clk, resetn        single clock, asynchronous active-low reset
//   ser_rx             raw serial input, synchronised internally
//   byte_if            master side of the byte stream (out_data/out_valid/out_ready)
//   fifo_level         bytes held, 0..2**FIFO_AW
//   frame_err, overrun sticky error flags, cleared by a one-cycle err_clr pulse
module uart_rx_fifo #(
  parameter int CLK_DIV = 104,  // clocks per bit, >= 8
  parameter int FIFO_AW = 2     // FIFO depth = 2**FIFO_AW
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ser_rx,
  uart_rx_fifo_if.master     byte_if,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               frame_err,
  output logic               overrun,
  input  logic               err_clr
);

  localparam int TW    = $clog2(CLK_DIV);
  localparam int CW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [TW-1:0] HALF_BIT = TW'(CLK_DIV / 2 - 1);
  localparam logic [TW-1:0] FULL_BIT = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser. Both flops reset high so the line looks idle
  // immediately after reset release and cannot fake a start bit.
  // ---------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= ser_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [2:0]    bit_idx, idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          tick;
  logic          push;
  logic          frame_set;

  assign tick = (timer == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      timer   <= timer_nx;
      bit_idx <= idx_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    idx_nx    = bit_idx;
    shreg_nx  = shreg;
    push      = 1'b0;
    frame_set = 1'b0;

    case (state)
      S_IDLE: begin
        // Half a bit period lands the start-bit check in the middle of the bit.
        if (!rx_s) begin
          timer_nx = HALF_BIT;
          state_nx = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            timer_nx = FULL_BIT;
            idx_nx   = 3'd0;
            state_nx = S_DATA;
          end else begin
            // Line went back high before mid-bit: treat as noise.
            state_nx = S_IDLE;
          end
        end else begin
          timer_nx = timer - TW'(1);
        end
      end

      S_DATA: begin
        if (tick) begin
          shreg_nx[bit_idx] = rx_s;
          timer_nx          = FULL_BIT;
          if (bit_idx == 3'd7) begin
            state_nx = S_STOP;
          end else begin
            idx_nx = bit_idx + 3'd1;
          end
        end else begin
          timer_nx = timer - TW'(1);
        end
      end

      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            push     = 1'b1;
            state_nx = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_nx  = S_BREAK;
          end
        end else begin
          timer_nx = timer - TW'(1);
        end
      end

      S_BREAK: begin
        // A held-low line (break) must return high before a new start is accepted.
        if (rx_s) begin
          state_nx = S_IDLE;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic               vld;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic               ovr_set;

  assign vld     = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = vld & byte_if.out_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign byte_if.out_data  = mem[rd_ptr];
  assign byte_if.out_valid = vld;
  assign fifo_level        = count;

  // ---------------------------------------------------------------------
  // Sticky error flags; a new error event beats a clear in the same cycle.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames driven bit by bit on ser_rx, outputs sampled on the falling edge.
// Ports: drives clk/resetn/ser_rx/err_clr and the consumer side of uart_rx_fifo_if.
// Expected values are hand-computed per step.
module tb_uart_rx_fifo;
  localparam int CLK_DIV = 104;

  logic       clk = 1'b0;
  logic       resetn;
  logic       ser_rx;
  logic       err_clr;
  logic [2:0] fifo_level;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo_if bus ();

  uart_rx_fifo #(
    .CLK_DIV (CLK_DIV),
    .FIFO_AW (2)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ser_rx     (ser_rx),
    .byte_if    (bus),
    .fifo_level (fifo_level),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Rising-edge counter and out_valid rise detector for latency measurement.
  int   cyc = 0;
  int   last_start = 0;
  int   rise_cyc = 0;
  logic vld_q = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && vld_q !== 1'b1) rise_cyc = cyc;
    vld_q = bus.out_valid;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame. Starts and ends on a falling edge. If pulse_at > 0,
  // out_ready is high for exactly the one cycle that begins pulse_at clocks
  // after the start edge. The line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pulse_at);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    last_start = cyc;
    for (int b = 0; b < 10; b++) begin
      ser_rx = bits[b];
      repeat (CLK_DIV) begin
        if (pulse_at > 0) bus.out_ready = (cyc == last_start + pulse_at);
        @(negedge clk);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  // Check the head byte, then accept it with a one-cycle ready pulse.
  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, 32'(bus.out_data), 32'(exp));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    resetn        = 1'b0;
    ser_rx        = 1'b1;
    err_clr       = 1'b0;
    bus.out_ready = 1'b0;
    idle(3);

    // Reset state
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  32'(bus.out_data),  32'h00);
    check("rst_level", 32'(fifo_level),    32'd0);
    check("rst_ferr",  32'(frame_err),     32'd0);
    check("rst_ovr",   32'(overrun),       32'd0);
    resetn = 1'b1;
    idle(5);

    // 1: single byte, latency about 2 sync + half bit + 9 bits after the start edge
    send_frame(8'hAA, 1'b1, 0);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_data",  32'(bus.out_data),  32'hAA);
    check("t1_level", 32'(fifo_level),    32'd1);
    check("t1_latency_window",
          32'((rise_cyc - last_start) >= 985 && (rise_cyc - last_start) <= 995), 32'd1);
    pop_check("t1_pop", 8'hAA);
    check("t1_level_after", 32'(fifo_level), 32'd0);
    check("t1_valid_after", 32'(bus.out_valid), 32'd0);

    // 2: 20-clock low glitch is rejected, then a normal frame
    ser_rx = 1'b0;
    idle(20);
    ser_rx = 1'b1;
    idle(200);
    check("t2_glitch_level", 32'(fifo_level), 32'd0);
    check("t2_glitch_valid", 32'(bus.out_valid), 32'd0);
    send_frame(8'h3C, 1'b1, 0);
    check("t2_level", 32'(fifo_level), 32'd1);
    pop_check("t2_data", 8'h3C);

    // 3: bad stop bit, line held low, then recovery and flag clear
    send_frame(8'h55, 1'b0, 0);
    idle(3 * CLK_DIV);
    check("t3_ferr",        32'(frame_err),  32'd1);
    check("t3_level",       32'(fifo_level), 32'd0);
    ser_rx = 1'b1;
    idle(2 * CLK_DIV);
    check("t3_break_level", 32'(fifo_level), 32'd0);
    send_frame(8'h81, 1'b1, 0);
    check("t3_level_good",  32'(fifo_level), 32'd1);
    pop_check("t3_data", 8'h81);
    check("t3_ferr_sticky", 32'(frame_err),  32'd1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t3_ferr_clr",    32'(frame_err),  32'd0);

    // 4: five bytes with no reads -> four held, fifth dropped
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0);
    check("t4_level_full", 32'(fifo_level), 32'd4);
    check("t4_ovr_before", 32'(overrun),    32'd0);
    send_frame(8'h05, 1'b1, 0);
    check("t4_level",      32'(fifo_level), 32'd4);
    check("t4_ovr",        32'(overrun),    32'd1);
    check("t4_ferr_clean", 32'(frame_err),  32'd0);
    pop_check("t4_rd1", 8'h01);
    pop_check("t4_rd2", 8'h02);
    pop_check("t4_rd3", 8'h03);
    pop_check("t4_rd4", 8'h04);
    check("t4_valid_empty", 32'(bus.out_valid), 32'd0);
    check("t4_level_empty", 32'(fifo_level),    32'd0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t4_ovr_clr", 32'(overrun), 32'd0);

    // 5: full FIFO, pop on the exact stop-sample cycle of the next byte
    //    (stop sample lands on the rising edge 991 clocks after the start edge)
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 0);
    check("t5_level_full", 32'(fifo_level), 32'd4);
    send_frame(8'h77, 1'b1, 990);
    check("t5_ovr",   32'(overrun),    32'd0);
    check("t5_level", 32'(fifo_level), 32'd4);
    pop_check("t5_rd1", 8'h11);
    pop_check("t5_rd2", 8'h12);
    pop_check("t5_rd3", 8'h13);
    pop_check("t5_rd4", 8'h77);
    check("t5_valid_empty", 32'(bus.out_valid), 32'd0);

    // 6: reset in the middle of a data bit with a byte queued and frame_err set
    send_frame(8'hF0, 1'b0, 0);
    idle(CLK_DIV);
    ser_rx = 1'b1;
    idle(CLK_DIV);
    send_frame(8'h5A, 1'b1, 0);
    check("t6_pre_level", 32'(fifo_level), 32'd1);
    check("t6_pre_ferr",  32'(frame_err),  32'd1);
    ser_rx = 1'b0;
    idle(CLK_DIV);
    ser_rx = 1'b1;          // bit0 of 0xC3
    idle(CLK_DIV / 2);
    resetn = 1'b0;
    idle(1);
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_data",  32'(bus.out_data),  32'h00);
    check("t6_rst_level", 32'(fifo_level),    32'd0);
    check("t6_rst_ferr",  32'(frame_err),     32'd0);
    check("t6_rst_ovr",   32'(overrun),       32'd0);
    idle(4);
    resetn = 1'b1;
    idle(3 * CLK_DIV);
    check("t6_no_false_start", 32'(fifo_level), 32'd0);
    send_frame(8'hC3, 1'b1, 0);
    check("t6_level", 32'(fifo_level), 32'd1);
    pop_check("t6_data", 8'hC3);
    check("t6_ferr_after", 32'(frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
